rvx_mailbox: RTL and testbench

RVX_MAILBOX -- requirements
Module: rvx_mailbox

---
 rtl/rvx_mailbox_pkg.sv | 45 ++++
 rtl/rvx_mailbox_fifo.sv | 65 ++++++
 rtl/rvx_mailbox.sv | 129 ++++++++++++
 tb/tb_rvx_mailbox.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rvx_mailbox_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rvx_mailbox_pkg                                           |
// | Brief    : Register map, STATUS/CONTROL bit positions, status packer |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package rvx_mailbox_pkg;

  localparam int c_count_w = 9;

  typedef enum logic [1:0] {
    REG_DATA      = 2'd0,
    REG_STATUS    = 2'd1,
    REG_CONTROL   = 2'd2,
    REG_THRESHOLD = 2'd3
  } reg_idx_e;

  localparam int c_stat_empty = 9;
  localparam int c_stat_full  = 10;
  localparam int c_stat_ovf   = 11;
  localparam int c_stat_unf   = 12;

  localparam int c_ctrl_flush = 0;
  localparam int c_ctrl_clear = 1;
  localparam int c_ctrl_ie    = 2;

  function automatic logic [31:0] status_word(
    input logic [c_count_w-1:0] count,
    input logic                 empty,
    input logic                 full,
    input logic                 ovf,
    input logic                 unf
  );
    logic [31:0] w_word;
    w_word                  = '0;
    w_word[c_count_w-1:0]   = count;
    w_word[c_stat_empty]    = empty;
    w_word[c_stat_full]     = full;
    w_word[c_stat_ovf]      = ovf;
    w_word[c_stat_unf]      = unf;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rvx_mailbox_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rvx_mailbox_fifo                                          |
// | Brief    : Circular word FIFO with occupancy count and flush         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rvx_mailbox_fifo
  import rvx_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [31:0]          push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic [31:0]          head_data,
  output logic [c_count_w-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int                   c_addr_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_addr_w-1:0]  c_ptr_one = c_addr_w'(1);
  localparam logic [c_count_w-1:0] c_depth   = c_count_w'(DEPTH);

  logic [31:0]          r_mem [DEPTH];
  logic [c_addr_w-1:0]  r_wr_ptr;
  logic [c_addr_w-1:0]  r_rd_ptr;
  logic [c_count_w-1:0] r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == c_depth);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  // Flush dominates: neither pointer nor count moves on a flush cycle.
  assign w_do_push = push && !full  && !flush;
  assign w_do_pop  = pop  && !empty && !flush;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 9'd1;
        2'b01:   r_count <= r_count - 9'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push && !reset) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/rvx_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rvx_mailbox                                               |
// | Brief    : Register-mapped mailbox FIFO; define RVX_MAILBOX_IRQ_EN   |
// |            for the THRESHOLD register, IE bit and level interrupt    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module rvx_mailbox
  import rvx_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rw_address,
  output logic [31:0] read_data,
  input  logic        read_request,
  output logic        read_response,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strobe,
  input  logic        write_request,
  output logic        write_response,
  output logic        irq
);

  reg_idx_e             w_index;
  logic                 w_data_wr;
  logic                 w_data_rd;
  logic                 w_push;
  logic                 w_ctrl_wr;
  logic                 w_flush;
  logic                 w_clear;
  logic [31:0]          w_head;
  logic [c_count_w-1:0] w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_ie;
  logic [c_count_w-1:0] w_threshold;
  logic [31:0]          w_rd_value;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 w_unused;

  assign w_index   = reg_idx_e'(rw_address[3:2]);
  assign w_unused  = &{1'b0, rw_address[31:4], rw_address[1:0]};

  assign w_data_wr = write_request && (w_index == REG_DATA);
  assign w_push    = w_data_wr && (write_strobe != 4'b0000);
  assign w_data_rd = read_request && (w_index == REG_DATA);
  assign w_ctrl_wr = write_request && (w_index == REG_CONTROL);
  assign w_flush   = w_ctrl_wr && write_data[c_ctrl_flush];
  assign w_clear   = w_ctrl_wr && write_data[c_ctrl_clear];

  rvx_mailbox_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .push_data (write_data),
    .pop       (w_data_rd),
    .flush     (w_flush),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_rd_value = '0;
    case (w_index)
      REG_DATA:      w_rd_value = w_empty ? 32'h0 : w_head;
      REG_STATUS:    w_rd_value = status_word(w_count, w_empty, w_full, r_ovf, r_unf);
      REG_CONTROL:   w_rd_value[c_ctrl_ie] = w_ie;
      REG_THRESHOLD: w_rd_value[c_count_w-1:0] = w_threshold;
      default:       w_rd_value = '0;
    endcase
  end

  // Sticky flags: a clear and a fresh event in the same cycle leaves the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      read_response  <= 1'b0;
      write_response <= 1'b0;
      read_data      <= '0;
      r_ovf          <= 1'b0;
      r_unf          <= 1'b0;
    end else begin
      read_response  <= read_request;
      write_response <= write_request;
      read_data      <= read_request ? w_rd_value : 32'h0;
      if (w_clear) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (w_push && w_full)     r_ovf <= 1'b1;
      if (w_data_rd && w_empty) r_unf <= 1'b1;
    end
  end

`ifdef RVX_MAILBOX_IRQ_EN
  logic                 r_ie;
  logic [c_count_w-1:0] r_threshold;
  logic                 r_irq;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ie        <= 1'b0;
      r_threshold <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= write_data[c_ctrl_ie];
      if (write_request && (w_index == REG_THRESHOLD))
        r_threshold <= write_data[c_count_w-1:0];
      r_irq <= r_ie && (((w_count >= r_threshold) && (w_count != '0)) || r_ovf);
    end
  end

  assign w_ie        = r_ie;
  assign w_threshold = r_threshold;
  assign irq         = r_irq;
`else
  assign w_ie        = 1'b0;
  assign w_threshold = '0;
  assign irq         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rvx_mailbox.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rvx_mailbox                                            |
// | Brief    : Directed plus random stimulus against a queue-based model |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_rvx_mailbox;

  localparam int DEPTH = 8;
`ifdef RVX_MAILBOX_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] q[$];
  bit          m_ovf, m_unf, m_ie;
  int          m_thr;
  logic [31:0] exp_rdata;
  bit          exp_rresp, exp_wresp, exp_irq;

  rvx_mailbox #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_request  (write_request),
    .write_response (write_response),
    .irq            (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a      = $urandom;
    a[3:2] = 2'(idx);
    return a;
  endfunction

  function automatic logic [31:0] m_status();
    int c;
    c = q.size();
    return (m_unf ? 32'h1000 : 32'h0) | (m_ovf ? 32'h0800 : 32'h0) |
           ((c == DEPTH) ? 32'h0400 : 32'h0) | ((c == 0) ? 32'h0200 : 32'h0) | 32'(c);
  endfunction

  // Reference behaviour of one clock edge, expressed on a word queue.
  task automatic model_step(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] st);
    int c   = q.size();
    int idx = int'(addr[3:2]);
    exp_rresp = rd;
    exp_wresp = wr;
    exp_rdata = 32'h0;
    if (rd) begin
      case (idx)
        0: exp_rdata = (c > 0) ? q[0] : 32'h0;
        1: exp_rdata = m_status();
        2: exp_rdata = m_ie ? 32'h4 : 32'h0;
        default: exp_rdata = 32'(m_thr);
      endcase
    end
    exp_irq = m_ie && (((c >= m_thr) && (c != 0)) || m_ovf);
    if (rd && idx == 0 && c > 0) void'(q.pop_front());
    if (wr && idx == 0 && st != 0 && c < DEPTH) q.push_back(wd);
    if (wr && idx == 2 && wd[1]) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (wr && idx == 0 && st != 0 && c == DEPTH) m_ovf = 1;
    if (rd && idx == 0 && c == 0) m_unf = 1;
    if (wr && idx == 2 && wd[0]) q.delete();
    if (IRQ_EN && wr && idx == 2) m_ie = wd[2];
    if (IRQ_EN && wr && idx == 3) m_thr = int'(wd[8:0]);
  endtask

  task automatic cycle(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st, input string tag);
    read_request  = rd;
    write_request = wr;
    rw_address    = addr;
    write_data    = wd;
    write_strobe  = st;
    model_step(rd, wr, addr, wd, st);
    @(posedge clock);
    #1;
    read_request  = 1'b0;
    write_request = 1'b0;
    check({tag, ".rresp"}, 32'(read_response), 32'(exp_rresp));
    check({tag, ".wresp"}, 32'(write_response), 32'(exp_wresp));
    check({tag, ".rdata"}, read_data, exp_rdata);
    check({tag, ".irq"}, 32'(irq), 32'(exp_irq));
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d, input string tag);
    cycle(1'b0, 1'b1, mk_addr(idx), d, 4'hF, tag);
  endtask

  task automatic rd_reg(input int idx, input string tag);
    cycle(1'b1, 1'b0, mk_addr(idx), $urandom, 4'h0, tag);
  endtask

  task automatic do_reset(input bit active, input string tag);
    reset         = 1'b1;
    read_request  = active;
    write_request = active;
    rw_address    = mk_addr(0);
    write_data    = 32'hDEAD_BEEF;
    write_strobe  = 4'hF;
    @(posedge clock);
    #1;
    reset         = 1'b0;
    read_request  = 1'b0;
    write_request = 1'b0;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_ie  = 0;
    m_thr = 0;
    check({tag, ".rresp"}, 32'(read_response), 32'h0);
    check({tag, ".wresp"}, 32'(write_response), 32'h0);
    check({tag, ".rdata"}, read_data, 32'h0);
    check({tag, ".irq"}, 32'(irq), 32'h0);
  endtask

  initial begin
    bit          rd, wr;
    logic [31:0] wd;
    logic [3:0]  st;
    int          r, idx;

    reset = 1'b1; read_request = 1'b0; write_request = 1'b0;
    rw_address = '0; write_data = '0; write_strobe = '0;
    do_reset(1'b0, "rst0");
    do_reset(1'b0, "rst1");
    rd_reg(1, "stat_rst");
    check("stat_rst_lit", read_data, 32'h0000_0200);

    for (int i = 1; i <= 3; i++) wr_reg(0, 32'hA5A5_0000 + 32'(i), "push3");
    for (int i = 1; i <= 3; i++) begin
      rd_reg(0, "pop3");
      check("pop3_lit", read_data, 32'hA5A5_0000 + 32'(i));
    end
    rd_reg(1, "stat_empty");
    check("stat_empty_lit", read_data, 32'h0000_0200);

    for (int i = 0; i < 9; i++) wr_reg(0, 32'h0000_1000 + 32'(i), "push9");
    rd_reg(1, "stat_full");
    check("stat_full_lit", read_data, 32'h0000_0C08);
    for (int i = 0; i < 8; i++) begin
      rd_reg(0, "drain8");
      check("drain8_lit", read_data, 32'h0000_1000 + 32'(i));
    end

    rd_reg(0, "unf_rd");
    check("unf_rd_lit", read_data, 32'h0);
    rd_reg(1, "stat_unf");
    check("stat_unf_lit", read_data, 32'h0000_1A00);
    wr_reg(2, 32'h2, "clr");
    rd_reg(1, "stat_clr");
    check("stat_clr_lit", read_data, 32'h0000_0200);

    for (int i = 0; i < 3; i++) wr_reg(0, 32'hB000_0000 + 32'(i), "fill3");
    cycle(1'b1, 1'b1, mk_addr(0), 32'h0000_1234, 4'h1, "simul");
    check("simul_lit", read_data, 32'hB000_0000);
    cycle(1'b0, 1'b1, mk_addr(0), 32'hFFFF_FFFF, 4'h0, "strb0");
    rd_reg(1, "stat_cnt3");
    check("stat_cnt3_lit", read_data, 32'h0000_0003);
    for (int i = 0; i < 3; i++) rd_reg(0, "drain3");
    check("last_lit", read_data, 32'h0000_1234);
    cycle(1'b1, 1'b1, mk_addr(0), 32'h0000_5678, 4'h8, "simul_empty");
    check("simul_empty_lit", read_data, 32'h0);
    rd_reg(1, "stat_simul_empty");
    check("stat_simul_empty_lit", read_data, 32'h0000_1001);
    wr_reg(2, 32'h3, "flush_clr");

    wr_reg(2, 32'h4, "ie_on");
    rd_reg(2, "ctrl_rd");
    check("ctrl_rd_lit", read_data, IRQ_EN ? 32'h4 : 32'h0);
    wr_reg(3, 32'h2, "thr_wr");
    wr_reg(0, 32'hC0, "irq_push");
    wr_reg(0, 32'hC1, "irq_push");
    rd_reg(3, "thr_rd");
    check("irq_hi_lit", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    rd_reg(0, "irq_pop");
    rd_reg(1, "irq_idle");
    check("irq_lo_lit", 32'(irq), 32'h0);
    wr_reg(2, 32'h1, "flush_ie_off");

    for (int i = 0; i < 500; i++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      idx = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 1;
      wd  = $urandom;
      if (idx == 3) wd[8:0] = 9'($urandom_range(0, DEPTH + 1));
      if (idx == 2 && $urandom_range(0, 3) != 0) wd[0] = 1'b0;
      st  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cycle(rd, wr, mk_addr(idx), wd, st, "rnd");
    end

    wr_reg(0, 32'hE0, "pre_rst");
    rd_reg(0, "pre_rst");
    rd_reg(0, "pre_rst");
    do_reset(1'b1, "rst_mid");
    rd_reg(1, "stat_after_rst");
    check("stat_after_rst_lit", read_data, 32'h0000_0200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
